// File: rtl/swc_rr_dispatch_pkg.sv
// Shared types and helpers for the swc round-robin grant dispatcher.
// Index-to-one-hot is sized for up to 63 ports.
package swc_rr_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    NEXT = 2'd2,
    GAP  = 2'd3
  } disp_state_e;

  localparam int unsigned SWC_DEFAULT_TIMEOUT = 1024;
  localparam int unsigned SWC_OH_W            = 64;
  localparam int unsigned SWC_IDX_W           = 6;

  function automatic logic [SWC_OH_W-1:0] swc_idx2oh(
    input logic [SWC_IDX_W-1:0] idx
  );
    logic [SWC_OH_W-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/swc_grant_watchdog.sv
// Ownership watchdog: counts OWN cycles and flags expiry at limit-1.
// Used by swc_rr_grant_dispatcher only with SWC_GRANT_TIMEOUT_EN.
module swc_grant_watchdog #(
  parameter int unsigned g_timeout_cycles = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o,
  output logic timeout_o
);

  localparam int unsigned CW = $clog2(g_timeout_cycles + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q;

  assign expire_o  = run_i && (cnt_q == CW'(g_timeout_cycles - 1));
  assign timeout_o = tmo_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= expire_o;
    end
  end

endmodule

// File: rtl/swc_rr_grant_dispatcher.sv
// Collects port requests for swc_rr_arbiter and turns its grant index into a level grant.
// Optional ownership watchdog and timeout_o port: define SWC_GRANT_TIMEOUT_EN.
module swc_rr_grant_dispatcher
  import swc_rr_dispatch_pkg::*;
#(
  parameter int unsigned g_num_ports      = 22,
  parameter int unsigned g_num_ports_log2 = 5,
  parameter int unsigned g_timeout_cycles = SWC_DEFAULT_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [g_num_ports-1:0]      port_req_i,
  input  logic [g_num_ports-1:0]      port_done_i,
  output logic [g_num_ports-1:0]      port_grant_o,
  output logic [g_num_ports-1:0]      arb_request_o,
  input  logic [g_num_ports_log2-1:0] arb_grant_i,
  input  logic                        arb_grant_valid_i,
  output logic                        arb_next_o,
  output logic                        busy_o
`ifdef SWC_GRANT_TIMEOUT_EN
  ,
  output logic                        timeout_o
`endif
);

  disp_state_e state_q, state_d;

  logic [g_num_ports-1:0] pend_q, pend_d;
  logic [g_num_ports-1:0] grant_q, grant_d;
  logic                   next_q, next_d;

  logic [SWC_OH_W-1:0]             sel_oh;
  logic [g_num_ports-1:0]          sel_lo;
  logic [SWC_OH_W-g_num_ports-1:0] sel_hi;
  logic                            accept;
  logic                            reject;
  logic                            done_hit;
  logic                            release_own;

  // Any bit above the port range means the index is out of range.
  assign sel_oh          = swc_idx2oh(SWC_IDX_W'(arb_grant_i));
  assign {sel_hi, sel_lo} = sel_oh;

  assign accept   = (state_q == IDLE) && arb_grant_valid_i &&
                    !(|sel_hi) && (|(sel_lo & pend_q));
  assign reject   = (state_q == IDLE) && arb_grant_valid_i && !accept;
  assign done_hit = |(port_done_i & grant_q);

`ifdef SWC_GRANT_TIMEOUT_EN
  logic expire;

  swc_grant_watchdog #(
    .g_timeout_cycles(g_timeout_cycles)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept),
    .run_i    (state_q == OWN),
    .expire_o (expire),
    .timeout_o(timeout_o)
  );

  assign release_own = done_hit || expire;
`else
  assign release_own = done_hit;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    next_d  = 1'b0;
    pend_d  = pend_q | port_req_i;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = OWN;
          grant_d = sel_lo;
          pend_d  = pend_d & ~sel_lo;
        end else if (reject) begin
          state_d = GAP;
          next_d  = 1'b1;
        end
      end
      OWN: begin
        if (release_own) begin
          state_d = NEXT;
          grant_d = '0;
          next_d  = 1'b1;
        end
      end
      NEXT:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      grant_q <= '0;
      next_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      next_q  <= next_d;
    end
  end

  assign port_grant_o  = grant_q;
  assign arb_request_o = pend_q;
  assign arb_next_o    = next_q;
  assign busy_o        = (state_q == OWN);

endmodule
